key_conditioner: RTL and testbench
==================================

# key_conditioner

Front-end input stage for the DE1-SoC top level, sitting directly upstream of the CPU and the instruction-word register. It synchronizes the raw KEY and SW pins to the board clock. It debounces each push-button with a per-key state machine and delivers clean levels plus single-cycle press and release pulses. The CPU's clk, reset, s and load drive from these conditioned signals instead of from the bouncing pins.

## Interface
- `N_KEYS`, default 4: number of push-buttons conditioned.
- `N_SW`, default 10: number of slide switches synchronized.
- `DEBOUNCE_CYCLES`, default 1_000_000: number of consecutive stable samples required to accept a key change (20 ms at 50 MHz). Must be ≥ 1.
- `clk`, input, 1: board clock (CLOCK_50). All state updates on its rising edge.
- `reset`, input, 1: synchronous, active-high. Clears all state on the next rising edge of `clk`.
- `key_n`, input, N_KEYS: raw push-buttons, active-low (0 = pushed), asynchronous.
- `sw_raw`, input, N_SW: raw slide switches, asynchronous.
- `key_level`, output, N_KEYS: debounced key state, active-high (1 = pushed).
- `key_press`, output, N_KEYS: one-cycle pulse when a push is accepted.
- `key_release`, output, N_KEYS: one-cycle pulse when a release is accepted.
- `sw_sync`, output, N_SW: switches after the 2-flop synchronizer.

## Operation
- **Synchronizer**
  - Two-flop synchronizer per bit on `key_n` and `sw_raw`.
  - Key synchronizer output is inverted to `pressed_s` (1 = pushed).
  - `sw_sync` is the second flop of the switch synchronizer. No debounce is applied to switches.
- **Per-key FSM**, four states with an independent counter `cnt` of width clog2(DEBOUNCE_CYCLES) (minimum 1):
  - **IDLE** (released): if `pressed_s`=1, go to PRESS_WAIT with `cnt`=0.
  - **PRESS_WAIT**:
    - If `pressed_s`=0, return to IDLE. No pulse.
    - Else if `cnt`==DEBOUNCE_CYCLES-1, go to PRESSED.
    - Else `cnt`++.
  - **PRESSED**: if `pressed_s`=0, go to RELEASE_WAIT with `cnt`=0.
  - **RELEASE_WAIT**:
    - If `pressed_s`=1, return to PRESSED. No pulse.
    - Else if `cnt`==DEBOUNCE_CYCLES-1, go to IDLE.
    - Else `cnt`++.
- **Outputs**, all registered:
  - `key_level`=1 in PRESSED and RELEASE_WAIT.
  - `key_press`=1 for exactly the one cycle following the PRESS_WAIT→PRESSED transition.
  - `key_release`=1 for exactly the one cycle following the RELEASE_WAIT→IDLE transition.
- **Independence**: keys never interact. Simultaneous presses on several keys produce simultaneous pulses.
- **Counter**: never wraps. It saturates by leaving the wait state at DEBOUNCE_CYCLES-1.
- **Reset** (synchronous, takes priority over every transition, including mid-wait):
  - FSMs to IDLE, `cnt`=0.
  - Key synchronizer flops to 1 (released).
  - Switch synchronizer flops to 0.
  - `key_level`, `key_press`, `key_release`, `sw_sync` all 0.
  - A key held through reset deassertion is accepted as a new press after the full latency.

## Timing
- Count edges from the first rising edge E0 at which a raw change is sampled.
- The FSM first sees `pressed_s` at E2.
- **Press latency**: if stable, PRESSED is entered at edge E(DEBOUNCE_CYCLES+2). `key_press` and `key_level` are high in the cycle after that edge.
- **Release latency**: symmetric, DEBOUNCE_CYCLES+2 edges from the sampled release.
- **Switch latency**: `sw_sync` follows `sw_raw` after 2 edges.
- **Glitch rejection**: a glitch of fewer than DEBOUNCE_CYCLES consecutive samples produces no level change and no pulse.
- **Pulse spacing**: minimum spacing between `key_press` pulses on one key is 2·(DEBOUNCE_CYCLES+1) cycles.

## Structure
- Shared package `input_pkg`:
  - Key FSM state encoding (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT, 2-bit).
  - Default debounce constant.
  - Counter-width function.
- Sub-module `key_debounce`: one FSM plus counter for a single key, taking `clk`, `reset`, `pressed_s` and producing `level`, `press`, `release`.
- `key_conditioner` holds the synchronizers and a generate loop of N_KEYS `key_debounce` instances.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- **Clean press**: reset, then hold `key_n[0]`=0. Required: `key_press[0]`=1 for exactly one cycle and `key_level[0]`=1, both 6 edges after the first sampled low. Other bits stay 0.
- **Bounce**: toggle `key_n[1]` low 3 cycles, high 1, low 2, high 1, then hold low. Required: no pulse during the bounce. Exactly one `key_press[1]`, 6 edges after the final sustained low.
- **Release**: after an accepted press on key 2, raise `key_n[2]` and hold. Required: `key_level[2]` drops and `key_release[2]` pulses once, 6 edges later. A 2-cycle high glitch while pressed produces neither.
- **Simultaneous**: press keys 0 and 3 on the same edge. Required: `key_press`=4'b1001 in a single cycle.
- **Reset mid-operation**: assert reset during PRESS_WAIT with the key held, then deassert. Required: all outputs 0 while reset is high. `key_press` fires 6 edges after reset deassertion.
- **Switches**: set `sw_raw`=10'h2A5. Required: `sw_sync`=10'h2A5 exactly 2 edges later, with no debounce delay.

Source files
------------

// File: rtl/input_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : input_pkg
//  Brief    : Shared key FSM encoding, default debounce and counter sizing.
//  Revision : 1.0 - initial release
// ============================================================================
package input_pkg;

    localparam logic [1:0] c_IDLE         = 2'd0;
    localparam logic [1:0] c_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] c_PRESSED      = 2'd2;
    localparam logic [1:0] c_RELEASE_WAIT = 2'd3;

    // 20 ms at 50 MHz
    localparam int c_DEBOUNCE_DEFAULT = 1_000_000;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : key_debounce
//  Brief    : Single-key debounce FSM with registered level/press/release.
//  Revision : 1.0 - initial release
// ============================================================================
module key_debounce
    import input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic pressed_s,
    output logic level,
    output logic press,
    output logic release_pulse
);

    localparam int            CW        = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] c_CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          r_level;
    logic          r_press;
    logic          r_release;
    logic          w_level_next;
    logic          w_press_next;
    logic          w_release_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_level   <= w_level_next;
            r_press   <= w_press_next;
            r_release <= w_release_next;
        end
    end

    // Counter saturates by leaving the wait state, so it never wraps.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            c_IDLE: begin
                if (pressed_s) begin
                    w_state_next = c_PRESS_WAIT;
                    w_cnt_next   = '0;
                end
            end
            c_PRESS_WAIT: begin
                if (!pressed_s) begin
                    w_state_next = c_IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == c_CNT_MAX) begin
                    w_state_next = c_PRESSED;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            c_PRESSED: begin
                if (!pressed_s) begin
                    w_state_next = c_RELEASE_WAIT;
                    w_cnt_next   = '0;
                end
            end
            c_RELEASE_WAIT: begin
                if (pressed_s) begin
                    w_state_next = c_PRESSED;
                    w_cnt_next   = '0;
                end else if (r_cnt == c_CNT_MAX) begin
                    w_state_next = c_IDLE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = c_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        w_level_next   = (w_state_next == c_PRESSED) || (w_state_next == c_RELEASE_WAIT);
        w_press_next   = (r_state == c_PRESS_WAIT) && (w_state_next == c_PRESSED);
        w_release_next = (r_state == c_RELEASE_WAIT) && (w_state_next == c_IDLE);
    end

    assign level         = r_level;
    assign press         = r_press;
    assign release_pulse = r_release;

endmodule
`default_nettype wire

// File: rtl/key_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : key_conditioner
//  Brief    : Synchronizes KEY/SW pins and debounces each push-button.
//  Revision : 1.0 - initial release
// ============================================================================
module key_conditioner
    import input_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int N_SW            = 10,
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_n,
    input  logic [N_SW-1:0]   sw_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_SW-1:0]   sw_sync
);

    logic [N_KEYS-1:0] r_key_meta;
    logic [N_KEYS-1:0] r_key_sync;
    logic [N_SW-1:0]   r_sw_meta;
    logic [N_SW-1:0]   r_sw_sync;
    logic [N_KEYS-1:0] w_pressed_s;

    // Key flops reset to the released (high) level so no phantom press follows reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_meta <= '1;
            r_key_sync <= '1;
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
        end else begin
            r_key_meta <= key_n;
            r_key_sync <= r_key_meta;
            r_sw_meta  <= sw_raw;
            r_sw_sync  <= r_sw_meta;
        end
    end

    assign w_pressed_s = ~r_key_sync;
    assign sw_sync     = r_sw_sync;

    generate
        for (genvar k = 0; k < N_KEYS; k++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_key_debounce (
                .clk           (clk),
                .reset         (reset),
                .pressed_s     (w_pressed_s[k]),
                .level         (key_level[k]),
                .press         (key_press[k]),
                .release_pulse (key_release[k])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_key_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_conditioner
//  Brief    : Directed self-checking bench for key_conditioner (debounce = 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_key_conditioner;

    localparam int N_KEYS = 4;
    localparam int N_SW   = 10;
    localparam int DB     = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [N_KEYS-1:0] key_n;
    logic [N_SW-1:0]   sw_raw;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [N_SW-1:0]   sw_sync;

    int errors = 0;
    int checks = 0;

    key_conditioner #(
        .N_KEYS         (N_KEYS),
        .N_SW           (N_SW),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_n       (key_n),
        .sw_raw      (sw_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .sw_sync     (sw_sync)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset  = 1'b1;
        key_n  = '1;
        sw_raw = '0;
        idle(3);
        chk("rst_level",   16'(key_level),   16'h0);
        chk("rst_press",   16'(key_press),   16'h0);
        chk("rst_release", 16'(key_release), 16'h0);
        chk("rst_sw",      16'(sw_sync),     16'h0);
        reset = 1'b0;
        tick();

        // Clean press on key 0: pulse on the 7th edge (E6)
        key_n = 4'b1110;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk($sformatf("clean_press_%0d", i), 16'(key_press), (i == DB + 3) ? 16'h1 : 16'h0);
            chk($sformatf("clean_level_%0d", i), 16'(key_level), (i >= DB + 3) ? 16'h1 : 16'h0);
        end
        key_n = 4'hF;
        idle(12);
        chk("clean_released", 16'(key_level), 16'h0);

        // Bounce on key 1: L3 H1 L2 H1 then hold low
        for (int i = 0; i < 7; i++) begin
            key_n[1] = (i == 3 || i == 6) ? 1'b1 : 1'b0;
            tick();
            chk($sformatf("bounce_quiet_%0d", i), 16'(key_press), 16'h0);
        end
        key_n[1] = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk($sformatf("bounce_press_%0d", i), 16'(key_press), (i == DB + 3) ? 16'h2 : 16'h0);
        end
        chk("bounce_level", 16'(key_level), 16'h2);
        key_n = 4'hF;
        idle(12);

        // Key 2: press, 2-cycle high glitch rejected, then real release
        key_n = 4'b1011;
        idle(9);
        chk("rel_pressed", 16'(key_level), 16'h4);
        key_n = 4'hF;
        idle(2);
        key_n = 4'b1011;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("glitch_level_%0d", i), 16'(key_level), 16'h4);
            chk($sformatf("glitch_rel_%0d", i), 16'(key_release), 16'h0);
        end
        key_n = 4'hF;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk($sformatf("rel_pulse_%0d", i), 16'(key_release), (i == DB + 3) ? 16'h4 : 16'h0);
            chk($sformatf("rel_level_%0d", i), 16'(key_level), (i >= DB + 3) ? 16'h0 : 16'h4);
        end
        idle(4);

        // Simultaneous press on keys 0 and 3
        key_n = 4'b0110;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk($sformatf("simul_press_%0d", i), 16'(key_press), (i == DB + 3) ? 16'h9 : 16'h0);
        end
        chk("simul_level", 16'(key_level), 16'h9);
        key_n = 4'hF;
        idle(12);

        // Reset asserted while key 0 is in PRESS_WAIT
        key_n = 4'b1110;
        idle(4);
        reset = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            tick();
            chk($sformatf("midrst_level_%0d", i), 16'(key_level), 16'h0);
            chk($sformatf("midrst_press_%0d", i), 16'(key_press), 16'h0);
            chk($sformatf("midrst_rel_%0d", i), 16'(key_release), 16'h0);
        end
        reset = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk($sformatf("postrst_press_%0d", i), 16'(key_press), (i == DB + 3) ? 16'h1 : 16'h0);
        end
        key_n = 4'hF;
        idle(12);

        // Switches: two-flop latency, no debounce
        sw_raw = 10'h2A5;
        tick();
        chk("sw_edge1", 16'(sw_sync), 16'h000);
        tick();
        chk("sw_edge2", 16'(sw_sync), 16'h2A5);
        sw_raw = 10'h15A;
        idle(2);
        chk("sw_second", 16'(sw_sync), 16'h15A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
